// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter through a launch FSM.
//
// Ports:
//   clk       - system clock; all state updates on the rising edge
//   reset_    - asynchronous, active-high reset; discards all stored bytes
//   wr_data   - byte to enqueue
//   wr_en     - enqueue request, sampled every clock
//   full      - registered, high when count == DEPTH
//   empty     - registered, high when count == 0
//   count     - registered number of stored bytes (AW+1 bits)
//   overflow  - sticky flag: an enqueue was dropped because the FIFO was full
//   ovf_clr   - clears overflow (a drop in the same cycle wins)
//   tx_ready  - UART core idle indication
//   txdata    - byte presented to the UART core, held until the next launch
//   tx_enable - single-cycle launch strobe, aligned with the new txdata
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr,
  input  logic          tx_ready,
  output logic [7:0]    txdata,
  output logic          tx_enable
);

  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [TW-1:0]   timer_r, timer_s;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [AW:0]     count_s;
  logic [7:0]      mem_r [DEPTH];
  logic            pop_s, push_s, drop_s;

  // A full FIFO still accepts a byte when the head is popped on the same edge.
  assign push_s = wr_en & (~full | pop_s);
  assign drop_s = wr_en & full & ~pop_s;

  // Launch FSM next-state logic; the pop is decided here from registered empty,
  // so a byte enqueued into an empty FIFO launches one cycle later at the earliest.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (~empty & tx_ready) begin
          pop_s   = 1'b1;
          state_s = WAIT_BUSY;
          timer_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_BUSY: begin
        // Busy indication has priority; a timeout returns to IDLE without re-sending.
        if (~tx_ready) begin
          state_s = WAIT_DONE;
        end else if (timer_r == TIMER_LAST) begin
          state_s = IDLE;
        end else begin
          timer_s = timer_r + TIMER_ONE;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_s = count;
    case ({push_s, pop_s})
      2'b10:   count_s = count + CNT_ONE;
      2'b01:   count_s = count - CNT_ONE;
      default: count_s = count;
    endcase
  end

  // Byte storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // FSM, pointers, flags and UART-facing outputs.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state_r   <= IDLE;
      timer_r   <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      txdata    <= 8'h00;
      tx_enable <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      count     <= count_s;
      full      <= (count_s == CNT_FULL);
      empty     <= (count_s == '0);
      tx_enable <= pop_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        // Reads the old head even when a same-edge write targets the same slot.
        txdata   <= mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (drop_s) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based reference model with
// launch timing expressed as timestamps, a simple UART busy model, directed
// scenarios with literal expectations, then a randomized phase.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int BT    = 8;

  logic        clk = 1'b0;
  logic        reset_;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        overflow;
  logic        ovf_clr;
  logic        tx_ready;
  logic [7:0]  txdata;
  logic        tx_enable;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .reset_(reset_), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .ovf_clr(ovf_clr), .tx_ready(tx_ready), .txdata(txdata), .tx_enable(tx_enable)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_txen;
  logic [7:0] m_txdata;
  int         cyc;
  int         launch_e, busy_e, done_e;

  // launch log and UART model
  logic [7:0] log_q[$];
  int         log_e[$];
  int         uart_mode;
  int         busy_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf    = 1'b0;
    m_txen   = 1'b0;
    m_txdata = 8'h00;
    launch_e = -1;
    busy_e   = -1;
    done_e   = -1;
  endtask

  // One rising edge of the model, using the inputs held across that edge.
  task automatic model_step();
    bit idle, pop, drop;
    int n_before;
    if (reset_) begin
      model_reset();
      return;
    end
    cyc++;
    // Launcher is free if nothing was launched, the busy window expired
    // unseen, or the transmitter has been seen busy and then ready again.
    idle = (launch_e < 0) || (busy_e < 0 && cyc - launch_e > BT) ||
           (done_e >= 0 && cyc > done_e);
    if (!idle) begin
      if (busy_e < 0) begin
        if (!tx_ready) busy_e = cyc;
      end else if (done_e < 0 && tx_ready) begin
        done_e = cyc;
      end
    end
    n_before = q.size();
    pop  = idle && (n_before > 0) && tx_ready;
    drop = 1'b0;
    if (pop) begin
      m_txdata = q.pop_front();
      m_txen   = 1'b1;
      launch_e = cyc;
      busy_e   = -1;
      done_e   = -1;
    end else begin
      m_txen = 1'b0;
    end
    if (wr_en) begin
      if (n_before < DEPTH || pop) q.push_back(wr_data);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  task automatic compare();
    chk("count",     int'(count),     q.size());
    chk("empty",     int'(empty),     int'(q.size() == 0));
    chk("full",      int'(full),      int'(q.size() == DEPTH));
    chk("overflow",  int'(overflow),  int'(m_ovf));
    chk("tx_enable", int'(tx_enable), int'(m_txen));
    chk("txdata",    int'(txdata),    int'(m_txdata));
  endtask

  task automatic uart_update();
    case (uart_mode)
      0: tx_ready = 1'b0;
      1: tx_ready = 1'b1;
      3: tx_ready = 1'($urandom_range(0, 1));
      default: begin
        if (tx_enable) busy_cnt = 10;
        else if (busy_cnt > 0) busy_cnt--;
        tx_ready = (busy_cnt == 0);
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    if (tx_enable) begin
      log_q.push_back(txdata);
      log_e.push_back(cyc);
    end
    uart_update();
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic clear_log();
    log_q.delete();
    log_e.delete();
  endtask

  initial begin
    int guard;
    reset_ = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
    tx_ready = 1'b0; uart_mode = 0; busy_cnt = 0; cyc = 0;
    model_reset();
    repeat (2) tick();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_txen", int'(tx_enable), 0);
    chk("rst_txdata", int'(txdata), 8'h00);

    // single byte with an always-ready transmitter
    reset_ = 1'b0; uart_mode = 1; tx_ready = 1'b1;
    tick();
    clear_log();
    push(8'hA5);
    repeat (12) tick();
    chk("a5_pulses", log_q.size(), 1);
    chk("a5_data", int'(log_q[0]), 8'hA5);
    chk("a5_empty", int'(empty), 1);

    // fill to full while the transmitter is held not-ready
    uart_mode = 0; tx_ready = 1'b0;
    clear_log();
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 16);
    chk("fill_no_launch", log_q.size(), 0);

    // dropped byte and sticky overflow
    push(8'h55);
    chk("drop_count", int'(count), 16);
    chk("drop_ovf", int'(overflow), 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("clr_ovf", int'(overflow), 0);
    ovf_clr = 1'b1; push(8'h66); ovf_clr = 1'b0;
    chk("clr_vs_drop_ovf", int'(overflow), 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("clr_again_ovf", int'(overflow), 0);

    // pop and enqueue on the same edge while full, then drain with a busy UART
    uart_mode = 2; busy_cnt = 0; tx_ready = 1'b1;
    push(8'h77);
    chk("swap_count", int'(count), 16);
    chk("swap_ovf", int'(overflow), 0);
    guard = 0;
    while (log_q.size() < 17 && guard < 400) begin
      tick();
      guard++;
    end
    chk("drain_timeout", int'(guard < 400), 1);
    chk("drain_pulses", log_q.size(), 17);
    for (int i = 0; i < 16; i++) chk("drain_order", int'(log_q[i]), i);
    chk("drain_last", int'(log_q[16]), 8'h77);
    chk("drain_spacing", log_e[1] - log_e[0], 12);
    repeat (20) tick();

    // transmitter never goes busy: busy window times out, no duplicate
    uart_mode = 1; tx_ready = 1'b1;
    clear_log();
    push(8'h11);
    push(8'h22);
    repeat (30) tick();
    chk("tmo_pulses", log_q.size(), 2);
    chk("tmo_first", int'(log_q[0]), 8'h11);
    chk("tmo_second", int'(log_q[1]), 8'h22);
    chk("tmo_gap", log_e[1] - log_e[0], 9);

    // asynchronous reset while waiting for the transmitter to finish
    uart_mode = 2; busy_cnt = 0; tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
    repeat (2) tick();
    chk("pre_rst_count", int'(count), 5);
    #2 reset_ = 1'b1;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_empty", int'(empty), 1);
    chk("async_rst_txen", int'(tx_enable), 0);
    model_reset(); busy_cnt = 0;
    repeat (2) tick();
    reset_ = 1'b0; uart_mode = 1; tx_ready = 1'b1;
    clear_log();
    repeat (20) tick();
    chk("post_rst_no_launch", log_q.size(), 0);
    push(8'hC3);
    repeat (5) tick();
    chk("post_rst_pulses", log_q.size(), 1);
    chk("post_rst_data", int'(log_q[0]), 8'hC3);

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      if (n % 250 == 0) uart_mode = $urandom_range(0, 3);
      wr_en   = ($urandom_range(0, 99) < 55);
      wr_data = 8'($urandom);
      ovf_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset_ = 1'b1;
        model_reset();
        tick();
        reset_ = 1'b0;
      end else begin
        tick();
      end
    end
    wr_en = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
